// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
// Build option: UART_TX_ARB_FIFO_EN selects per-requester FIFOs instead of holding registers.
package uart_tx_arb_pkg;

    localparam int NUM_REQ      = 2;
    localparam int BUSY_TIMEOUT = 4;
    localparam int BUSY_CNT_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    // Round-robin pick: a lone pending requester wins, otherwise the one not served last.
    function automatic logic pick_winner(input logic [NUM_REQ-1:0] pending,
                                         input logic               last_grant);
        logic win;
        case (pending)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_grant;
            default: win = ~last_grant;
        endcase
        return win;
    endfunction

endpackage

// File: rtl/uart_tx_arb_fifo.sv
// Synchronous FIFO holding queued bytes for one requester.
// Used only when UART_TX_ARB_FIFO_EN is defined; DEPTH must be a power of two.
module uart_tx_arb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign head_data = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte requesters onto a single UART transmitter with round-robin fairness.
// Build option: UART_TX_ARB_FIFO_EN gives each requester a FIFO_DEPTH-entry queue.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] sdata,
    input  logic       tx_busy,
    output logic       last_grant
);

    arb_state_e              state_r;
    arb_state_e              state_s;
    logic [NUM_REQ-1:0]      valid_s;
    logic [NUM_REQ-1:0]      push_s;
    logic [NUM_REQ-1:0]      pop_s;
    logic [NUM_REQ-1:0]      full_s;
    logic [NUM_REQ-1:0]      empty_s;
    logic [7:0]              data_s [NUM_REQ];
    logic [7:0]              head_s [NUM_REQ];
    logic                    win_s;
    logic                    winner_r;
    logic                    last_grant_r;
    logic                    tx_start_r;
    logic [7:0]              sdata_r;
    logic [BUSY_CNT_W-1:0]   wait_cnt_r;

    assign valid_s    = {req1_valid, req0_valid};
    assign data_s[0]  = req0_data;
    assign data_s[1]  = req1_data;
    assign push_s     = valid_s & ~full_s;
    assign req0_ready = ~full_s[0];
    assign req1_ready = ~full_s[1];
    assign tx_start   = tx_start_r;
    assign sdata      = sdata_r;
    assign last_grant = last_grant_r;

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
`ifdef UART_TX_ARB_FIFO_EN
            uart_tx_arb_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (8)
            ) u_fifo (
                .clock     (clock),
                .resetn    (resetn),
                .push      (push_s[g]),
                .push_data (data_s[g]),
                .pop       (pop_s[g]),
                .full      (full_s[g]),
                .empty     (empty_s[g]),
                .head_data (head_s[g])
            );
`else
            logic       hold_valid_r;
            logic [7:0] hold_data_r;

            // Single-byte holding register; push needs it empty and pop needs it full.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    hold_valid_r <= 1'b0;
                    hold_data_r  <= 8'h00;
                end else if (push_s[g]) begin
                    hold_valid_r <= 1'b1;
                    hold_data_r  <= data_s[g];
                end else if (pop_s[g]) begin
                    hold_valid_r <= 1'b0;
                end else begin
                    hold_valid_r <= hold_valid_r;
                end
            end

            assign full_s[g]  = hold_valid_r;
            assign empty_s[g] = ~hold_valid_r;
            assign head_s[g]  = hold_data_r;
`endif
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic, winner selection and the pop strobe issued in START.
    always_comb begin
        state_s = state_r;
        pop_s   = {NUM_REQ{1'b0}};
        win_s   = pick_winner(~empty_s, last_grant_r);
        case (state_r)
            ST_IDLE: begin
                if (!tx_busy && (|(~empty_s))) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                pop_s[winner_r] = 1'b1;
                state_s         = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_s = ST_WAIT_DONE;
                end else if (wait_cnt_r == BUSY_CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Registered launch outputs; the winner is frozen on leaving IDLE so START pops the right slot.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            winner_r     <= 1'b0;
            last_grant_r <= 1'b1;
            tx_start_r   <= 1'b0;
            sdata_r      <= 8'h00;
            wait_cnt_r   <= {BUSY_CNT_W{1'b0}};
        end else begin
            tx_start_r <= (state_r == ST_START);
            if (state_r == ST_IDLE) begin
                winner_r <= win_s;
            end else begin
                winner_r <= winner_r;
            end
            if (state_r == ST_START) begin
                sdata_r      <= head_s[winner_r];
                last_grant_r <= winner_r;
                wait_cnt_r   <= {BUSY_CNT_W{1'b0}};
            end else if (state_r == ST_WAIT_BUSY) begin
                wait_cnt_r   <= wait_cnt_r + BUSY_CNT_W'(1);
            end else begin
                wait_cnt_r   <= wait_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner cases and random traffic
// checked by a queue-based model of acceptance order and round-robin fairness.
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clock = 1'b0;
    logic       resetn;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       tx_start;
    logic [7:0] sdata;
    logic       tx_busy;
    logic       last_grant;

    uart_tx_arbiter #(.FIFO_DEPTH(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .tx_start   (tx_start),
        .sdata      (sdata),
        .tx_busy    (tx_busy),
        .last_grant (last_grant)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: bytes accepted but not yet launched, per requester.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] src0[$];
    logic [7:0] src1[$];
    logic [7:0] log_data[$];
    logic       log_grant[$];
    int         log_cyc[$];
    logic       mdl_grant;
    bit         fair_pending;
    logic       prev_start;
    bit         acc0, acc1;
    int         acc_cyc0;
    int         cyc;
    bit         auto_uart;
    int         busy_len;
    int         busy_cnt;
    bit         start_seen;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        int         n;
        logic [7:0] e0;
        logic       g0;
        logic [7:0] e1;
        logic       g1;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic on_negedge();
        logic       r;
        logic [8:0] exp_b;
        bit         m0, m1;
        cyc++;
        if (tx_start) begin
            check("start_one_cycle", prev_start, 1'b0);
            check("start_while_busy", tx_busy, 1'b0);
            m0 = (q0.size() > 0) && (q0[0] == sdata);
            m1 = (q1.size() > 0) && (q1[0] == sdata);
            if (fair_pending)    r = ~mdl_grant;
            else if (m1 && !m0)  r = 1'b1;
            else if (m0)         r = 1'b0;
            else                 r = (q0.size() == 0);
            if (r == 1'b0) exp_b = (q0.size() > 0) ? {1'b0, q0[0]} : 9'h100;
            else           exp_b = (q1.size() > 0) ? {1'b0, q1[0]} : 9'h100;
            check("launch_data", {1'b0, sdata}, exp_b);
            check("last_grant", last_grant, r);
            if (r == 1'b0 && q0.size() > 0) void'(q0.pop_front());
            if (r == 1'b1 && q1.size() > 0) void'(q1.pop_front());
            mdl_grant    = r;
            fair_pending = (r == 1'b0) ? (q1.size() > 0) : (q0.size() > 0);
            log_data.push_back(sdata);
            log_grant.push_back(r);
            log_cyc.push_back(cyc);
            start_seen = 1'b1;
        end
        prev_start = tx_start;
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (acc0) begin
            q0.push_back(req0_data);
            acc_cyc0 = cyc;
        end
        if (acc1) q1.push_back(req1_data);
    endtask

    // One clock: observe at the falling edge, then update UART model and requesters after the rise.
    task automatic step();
        @(negedge clock);
        on_negedge();
        @(posedge clock);
        #1;
        if (auto_uart) begin
            if (start_seen) begin
                busy_cnt   = busy_len;
                start_seen = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            tx_busy = (busy_cnt > 0);
        end
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
        if (!req0_valid && src0.size() > 0) begin
            req0_valid = 1'b1;
            req0_data  = src0.pop_front();
        end
        if (!req1_valid && src1.size() > 0) begin
            req1_valid = 1'b1;
            req1_data  = src1.pop_front();
        end
    endtask

    task automatic clear_model();
        q0.delete(); q1.delete(); src0.delete(); src1.delete();
        log_data.delete(); log_grant.delete(); log_cyc.delete();
        mdl_grant = 1'b1; fair_pending = 1'b0; prev_start = 1'b0;
        acc0 = 1'b0; acc1 = 1'b0; busy_cnt = 0; start_seen = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; tx_busy = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_model();
        step();
        step();
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_sdata", sdata, 8'h00);
        check("rst_last_grant", last_grant, 1'b1);
        check("rst_ready0", req0_ready, 1'b1);
        check("rst_ready1", req1_ready, 1'b1);
        resetn = 1'b1;
    endtask

    task automatic wait_launches(input int n, input int budget);
        int k;
        k = 0;
        while (log_data.size() < n && k < budget) begin
            step();
            k++;
        end
        check("launch_wait", (log_data.size() >= n), 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 8'h41, 1'b0, 8'h00, 1, 8'h41, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1, 8'h3C, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 8'hAA, 1'b1, 8'h55, 2, 8'hAA, 1'b0, 8'h55, 1'b1};
        vecs[3] = '{1'b1, 8'h7E, 1'b1, 8'h81, 2, 8'h7E, 1'b0, 8'h81, 1'b1};
        vecs[4] = '{1'b1, 8'h00, 1'b1, 8'hFF, 2, 8'h00, 1'b0, 8'hFF, 1'b1};

        resetn = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
        cyc = 0; acc_cyc0 = 0; auto_uart = 1'b1; busy_len = 6;
        clear_model();

        // Vector table: bytes offered in the same cycle after reset.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            auto_uart = 1'b1;
            busy_len  = 6;
            if (vecs[i].v0) src0.push_back(vecs[i].d0);
            if (vecs[i].v1) src1.push_back(vecs[i].d1);
            wait_launches(vecs[i].n, 100);
            repeat (12) step();
            check("vec_count", log_data.size(), vecs[i].n);
            if (log_data.size() > 0) begin
                check("vec_first_data", log_data[0], vecs[i].e0);
                check("vec_first_grant", log_grant[0], vecs[i].g0);
            end
            if (vecs[i].n == 2 && log_data.size() > 1) begin
                check("vec_second_data", log_data[1], vecs[i].e1);
                check("vec_second_grant", log_grant[1], vecs[i].g1);
            end
        end

        // Single byte with a 20-cycle busy: latency, held sdata, ready recovery.
        do_reset();
        busy_len = 20;
        src0.push_back(8'h41);
        wait_launches(1, 20);
        // The handshake is observed on the falling edge before the accepting rise.
        if (log_cyc.size() > 0) check("latency_2_cycles", log_cyc[0] - acc_cyc0, 3);
        repeat (30) step();
        check("single_start_count", log_data.size(), 1);
        check("single_sdata_held", sdata, 8'h41);
        check("single_last_grant", last_grant, 1'b0);
        check("single_ready0", req0_ready, 1'b1);

        // Two continuous streams alternate.
        do_reset();
        busy_len = 3;
        for (int i = 0; i < 4; i++) begin
            src0.push_back(8'(8'h01 + i));
            src1.push_back(8'(8'h10 + i));
        end
        wait_launches(8, 200);
        for (int i = 0; i < 8 && i < log_data.size(); i++) begin
            check("stream_order", log_data[i], (i % 2 == 0) ? 8'(8'h01 + i / 2) : 8'(8'h10 + i / 2));
        end

        // Busy already high before the request.
        do_reset();
        auto_uart = 1'b0;
        tx_busy   = 1'b1;
        src0.push_back(8'h5A);
        repeat (10) step();
        check("busy_hold_no_start", log_data.size(), 0);
        tx_busy = 1'b0;
        step();
        step();
        check("busy_release_start", tx_start, 1'b1);
        check("busy_release_sdata", sdata, 8'h5A);
        repeat (8) step();

        // Lost start: busy never rises, next byte launches after the timeout.
        do_reset();
        auto_uart = 1'b1;
        busy_len  = 0;
        src0.push_back(8'h21);
        src0.push_back(8'h22);
        wait_launches(2, 60);
        if (log_cyc.size() > 1) begin
            check("timeout_gap", log_cyc[1] - log_cyc[0], 6);
            check("timeout_second_data", log_data[1], 8'h22);
        end

        // Back-pressure with busy stuck high, then drain.
        do_reset();
        auto_uart = 1'b0;
        tx_busy   = 1'b1;
        for (int i = 0; i < CAP + 1; i++) src1.push_back(8'(8'h91 + i));
        repeat (12) step();
        check("bp_accepted", q1.size(), CAP);
        check("bp_ready_low", req1_ready, 1'b0);
        check("bp_no_start", log_data.size(), 0);
        tx_busy   = 1'b0;
        auto_uart = 1'b1;
        busy_len  = 4;
        wait_launches(CAP + 1, 300);
        repeat (10) step();
        for (int i = 0; i < CAP + 1 && i < log_data.size(); i++) begin
            check("bp_order", log_data[i], 8'(8'h91 + i));
        end
        check("bp_drained", q1.size(), 0);
        check("bp_ready_back", req1_ready, 1'b1);

        // Reset in the middle of a transmission with another byte pending.
        do_reset();
        busy_len = 20;
        src0.push_back(8'h33);
        wait_launches(1, 20);
        src1.push_back(8'h44);
        repeat (5) step();
        resetn = 1'b0;
        #1;
        check("midrst_tx_start", tx_start, 1'b0);
        check("midrst_sdata", sdata, 8'h00);
        check("midrst_last_grant", last_grant, 1'b1);
        check("midrst_ready0", req0_ready, 1'b1);
        check("midrst_ready1", req1_ready, 1'b1);
        clear_model();
        step();
        step();
        resetn = 1'b1;
        repeat (15) step();
        check("midrst_no_launch", log_data.size(), 0);

        // Random traffic: requester 0 sends 0x00-0x7F, requester 1 sends 0x80-0xFF.
        do_reset();
        auto_uart = 1'b1;
        for (int c = 0; c < 800; c++) begin
            busy_len = $urandom_range(0, 6);
            if (src0.size() < 3 && $urandom_range(0, 2) == 0) src0.push_back(8'($urandom_range(0, 127)));
            if (src1.size() < 3 && $urandom_range(0, 2) == 0) src1.push_back(8'($urandom_range(128, 255)));
            step();
        end
        for (int c = 0; c < 600; c++) begin
            if (q0.size() == 0 && q1.size() == 0 && src0.size() == 0 && src1.size() == 0
                && !req0_valid && !req1_valid) break;
            step();
        end
        check("rand_q0_drained", q0.size(), 0);
        check("rand_q1_drained", q1.size(), 0);
        check("rand_src_drained", src0.size() + src1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
